// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encoding, relock
// counter width and default cycle constants for a 27 MHz reference clock.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } sup_state_e;

  localparam int RELOCK_CNT_W = 8;

  // 27 MHz: 1 us PLL reset pulse, 10 ms lock timeout, 100 us stability window
  localparam int DEF_PLL_RST_CYC      = 27;
  localparam int DEF_LOCK_TIMEOUT_CYC = 270000;
  localparam int DEF_STABLE_CYC       = 2700;
  localparam int DEF_SYNC_STAGES      = 2;

  // Largest of three cycle counts; sizes the shared state counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit clock-domain-crossing synchronizer: a STAGES-deep flop chain
// reset asynchronously to 0. Only level signals belong here; pulses shorter
// than one destination clock period can be missed.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  // Shift the asynchronous input through the chain, oldest sample at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor. Pulses the PLL reset, waits for lock (re-pulsing on
// timeout), requires lock to stay up for a stability window, then releases
// the downstream reset. Loss of lock in RUN goes back to WAIT_LOCK so the PLL
// can relock by itself, and is counted in a saturating relock counter.
// All outputs decode only the state register, so no input reaches an output
// combinationally.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYC      = DEF_PLL_RST_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int STABLE_CYC       = DEF_STABLE_CYC,
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES
) (
  input  logic                    I_clk,
  input  logic                    I_rst_n,
  input  logic                    I_pll_lock,
  output logic                    O_pll_reset,
  output logic                    O_rst_n,
  output logic                    O_locked,
  output logic [RELOCK_CNT_W-1:0] O_relock_cnt,
  output logic [1:0]              O_state
);

  localparam int CNT_W = $clog2(max3(PLL_RST_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC)) + 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);

  logic                    lock_s;
  sup_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RELOCK_CNT_W-1:0] relock_q, relock_d;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .d     (I_pll_lock),
    .q     (lock_s)
  );

  // State, cycle counter and relock counter registers
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= PLL_RST;
      cnt_q    <= '0;
      relock_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      relock_q <= relock_d;
    end
  end

  // Next-state, counter and relock-count decisions
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    relock_d = relock_q;
    case (state_q)
      PLL_RST: begin
        // Lock is ignored here; the pulse is exactly PLL_RST_CYC cycles
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a timeout in the same cycle
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = PLL_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE: begin
        // A glitch restarts the whole timeout window
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          if (relock_q != '1) begin
            relock_d = relock_q + RELOCK_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  assign O_pll_reset  = (state_q == PLL_RST);
  assign O_rst_n      = (state_q == RUN);
  assign O_locked     = (state_q == RUN);
  assign O_relock_cnt = relock_q;
  assign O_state      = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small cycle parameters
// (PLL reset 4, timeout 50, stability 10, two sync stages).
module tb_pll_lock_supervisor;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       pll_reset;
  logic       dn_rst_n;
  logic       locked;
  logic [7:0] relock_cnt;
  logic [1:0] state;

  int vectors;
  int miscompares;

  pll_lock_supervisor #(
    .PLL_RST_CYC      (4),
    .LOCK_TIMEOUT_CYC (50),
    .STABLE_CYC       (10),
    .SYNC_STAGES      (2)
  ) dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_pll_lock   (pll_lock),
    .O_pll_reset  (pll_reset),
    .O_rst_n      (dn_rst_n),
    .O_locked     (locked),
    .O_relock_cnt (relock_cnt),
    .O_state      (state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock: through the rising edge, then back to the falling edge where
  // inputs change and outputs are sampled
  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full reset-pulse / wait window with lock low; starts at a fresh PLL_RST
  // entry and ends at the next one
  task automatic pulse_window(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_rst_hi"}, pll_reset, 1);
      chk({tag, "_rst_state"}, state, 0);
      chk({tag, "_rst_dn"}, dn_rst_n, 0);
      cycle(1);
    end
    for (int i = 0; i < 50; i++) begin
      chk({tag, "_wait_lo"}, pll_reset, 0);
      chk({tag, "_wait_state"}, state, 1);
      chk({tag, "_wait_locked"}, locked, 0);
      cycle(1);
    end
    chk({tag, "_repulse"}, pll_reset, 1);
    chk({tag, "_repulse_state"}, state, 0);
  endtask

  // Raise lock from WAIT_LOCK and check RUN is reached on exactly the 13th edge
  task automatic lock_to_run(input string tag);
    pll_lock = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cycle(1);
      chk({tag, "_pre_run"}, dn_rst_n, 0);
    end
    cycle(1);
    chk({tag, "_run_rst_n"}, dn_rst_n, 1);
    chk({tag, "_run_locked"}, locked, 1);
    chk({tag, "_run_state"}, state, 3);
  endtask

  // Stimulus
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    pll_lock    = 1'b0;

    // Reset state
    #2;
    chk("reset_pll_reset", pll_reset, 1);
    chk("reset_rst_n", dn_rst_n, 0);
    chk("reset_locked", locked, 0);
    chk("reset_state", state, 0);
    chk("reset_relock", relock_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1) lock held low: 4 high / 50 low repeating
    pulse_window("t1a");
    pulse_window("t1b");

    // 3) lock high for a while in STABLE, then a glitch back to WAIT_LOCK
    cycle(4);
    chk("t3_in_wait", state, 1);
    pll_lock = 1'b1;
    cycle(3);
    chk("t3_in_stable", state, 2);
    cycle(5);
    chk("t3_still_stable", state, 2);
    chk("t3_rst_n_low", dn_rst_n, 0);
    pll_lock = 1'b0;
    cycle(2);
    chk("t3_fall_pending", state, 2);
    cycle(1);
    chk("t3_back_wait", state, 1);
    chk("t3_rst_n_stays", dn_rst_n, 0);
    for (int i = 0; i < 49; i++) begin
      cycle(1);
      chk("t3_window_lo", pll_reset, 0);
    end
    cycle(1);
    chk("t3_next_pulse", pll_reset, 1);

    // 2) lock rises in WAIT_LOCK and is held
    cycle(4);
    chk("t2_in_wait", state, 1);
    cycle(3);
    lock_to_run("t2");
    chk("t2_relock", relock_cnt, 0);

    // 4) lock lost for 20 cycles in RUN, then restored
    cycle(3);
    pll_lock = 1'b0;
    cycle(2);
    chk("t4_fall_pending", dn_rst_n, 1);
    cycle(1);
    chk("t4_rst_n_low", dn_rst_n, 0);
    chk("t4_state_wait", state, 1);
    chk("t4_relock", relock_cnt, 1);
    cycle(17);
    chk("t4_hold_wait", state, 1);
    lock_to_run("t4");
    chk("t4_relock_after", relock_cnt, 1);

    // 5) saturation of the relock counter over 300 losses
    for (int i = 0; i < 253; i++) begin
      pll_lock = 1'b0;
      cycle(3);
      pll_lock = 1'b1;
      cycle(13);
    end
    chk("t5_relock_254", relock_cnt, 254);
    chk("t5_state_run", state, 3);
    pll_lock = 1'b0;
    cycle(3);
    pll_lock = 1'b1;
    cycle(13);
    chk("t5_relock_255", relock_cnt, 255);
    for (int i = 0; i < 46; i++) begin
      pll_lock = 1'b0;
      cycle(3);
      pll_lock = 1'b1;
      cycle(13);
    end
    chk("t5_relock_sat", relock_cnt, 255);
    chk("t5_state_run_end", state, 3);

    // 6) asynchronous reset in the middle of STABLE
    pll_lock = 1'b0;
    cycle(3);
    chk("t6_wait", state, 1);
    pll_lock = 1'b1;
    cycle(4);
    chk("t6_stable", state, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_pll_reset", pll_reset, 1);
    chk("t6_async_rst_n", dn_rst_n, 0);
    chk("t6_async_locked", locked, 0);
    chk("t6_async_state", state, 0);
    chk("t6_async_relock", relock_cnt, 0);
    pll_lock = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_window("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
